pp_1: RTL and testbench



---
 rtl/pp_1.sv | 100 ++++++++++
 tb/tb_pp_1.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pp_1.sv
// Moore detector for the two-step handshake (x,y)=(1,0) then (0,1), producing a PULSE_LEN-cycle pulse on q.
// Optional saturating detection counter on det_count when PP_1_DET_COUNT_EN is defined.
module pp_1 #(
    parameter int unsigned PULSE_LEN = 1,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             x,
    input  logic             y,
    input  logic             Rst,
    input  logic             Clk,
    output logic             q
`ifdef PP_1_DET_COUNT_EN
    ,
    output logic [CNT_W-1:0] det_count
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GOT_X  = 2'd1,
        DETECT = 2'd2
    } state_e;

    localparam logic [7:0] PulseLoad = 8'(PULSE_LEN - 1);

    state_e     state_q, state_d;
    logic [7:0] pulseCnt_q, pulseCnt_d;
    logic       q_q;
    logic       reqPair;
    logic       ackPair;

    assign reqPair = x & ~y;
    assign ackPair = ~x & y;

    // The pulse counter holds the number of DETECT cycles still to come after the current one.
    always_comb begin
        state_d    = IDLE;
        pulseCnt_d = pulseCnt_q;
        case (state_q)
            IDLE: begin
                state_d = reqPair ? GOT_X : IDLE;
            end
            GOT_X: begin
                if (ackPair) begin
                    state_d    = DETECT;
                    pulseCnt_d = PulseLoad;
                end else if (reqPair) begin
                    state_d = GOT_X;
                end else begin
                    state_d = IDLE;
                end
            end
            DETECT: begin
                if (pulseCnt_q != 8'd0) begin
                    state_d    = DETECT;
                    pulseCnt_d = pulseCnt_q - 8'd1;
                end else begin
                    state_d = reqPair ? GOT_X : IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                pulseCnt_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= IDLE;
            pulseCnt_q <= 8'd0;
            q_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            pulseCnt_q <= pulseCnt_d;
            q_q        <= (state_d == DETECT);
        end
    end

    assign q = q_q;

`ifdef PP_1_DET_COUNT_EN
    logic [CNT_W-1:0] detCount_q;
    logic             detectEvent;

    assign detectEvent = (state_q == GOT_X) && ackPair;

    // Counts completed handshakes and sticks at all-ones instead of wrapping.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            detCount_q <= '0;
        end else if (detectEvent && (detCount_q != {CNT_W{1'b1}})) begin
            detCount_q <= detCount_q + 1'b1;
        end
    end

    assign det_count = detCount_q;
`endif

endmodule

// File: tb/tb_pp_1.sv
// Scoreboard bench for pp_1: two instances (PULSE_LEN 1 and 3) share one directed input stream.
// The PULSE_LEN=3 instance uses CNT_W=2 so the saturating det_count is exercised when PP_1_DET_COUNT_EN is set.
module tb_pp_1;

    typedef struct {
        int         idx;
        logic       qA;
        logic       qB;
        logic [1:0] det;
    } exp_t;

    logic Clk;
    logic Rst;
    logic x;
    logic y;
    logic qA;
    logic qB;
`ifdef PP_1_DET_COUNT_EN
    logic [7:0] detA;
    logic [1:0] detB;
`endif

    exp_t sbQ[$];
    int   checkCount;
    int   failCount;

    // Each row: {rst, x, y, expected qA, expected qB, expected det_count of B}, values after that edge.
    logic [6:0] vecs [37] = '{
        7'b1_00_0_0_00,
        7'b0_10_0_0_00,
        7'b0_01_1_1_01,
        7'b0_00_0_1_01,
        7'b0_00_0_1_01,
        7'b0_00_0_0_01,
        7'b0_01_0_0_01,
        7'b0_10_0_0_01,
        7'b0_00_0_0_01,
        7'b0_10_0_0_01,
        7'b0_11_0_0_01,
        7'b0_01_0_0_01,
        7'b0_10_0_0_01,
        7'b0_10_0_0_01,
        7'b0_01_1_1_10,
        7'b0_10_0_1_10,
        7'b0_01_1_1_10,
        7'b0_10_0_0_10,
        7'b0_01_1_1_11,
        7'b0_00_0_1_11,
        7'b0_00_0_1_11,
        7'b0_00_0_0_11,
        7'b0_10_0_0_11,
        7'b0_01_1_1_11,
        7'b0_00_0_1_11,
        7'b0_00_0_1_11,
        7'b0_00_0_0_11,
        7'b0_10_0_0_11,
        7'b0_01_1_1_11,
        7'b0_00_0_1_11,
        7'b1_10_0_0_00,
        7'b0_10_0_0_00,
        7'b1_01_0_0_00,
        7'b0_10_0_0_00,
        7'b0_01_1_1_01,
        7'b1_00_0_0_00,
        7'b0_00_0_0_00
    };

    pp_1 #(.PULSE_LEN(1), .CNT_W(8)) dutA (
        .x(x),
        .y(y),
        .Rst(Rst),
        .Clk(Clk),
        .q(qA)
`ifdef PP_1_DET_COUNT_EN
        ,
        .det_count(detA)
`endif
    );

    pp_1 #(.PULSE_LEN(3), .CNT_W(2)) dutB (
        .x(x),
        .y(y),
        .Rst(Rst),
        .Clk(Clk),
        .q(qB)
`ifdef PP_1_DET_COUNT_EN
        ,
        .det_count(detB)
`endif
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic checkOutput(input string name, input int idx, input logic [7:0] actual,
                               input logic [7:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s row %0d: got %0d, expected %0d", name, idx, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int idx);
        logic [6:0] v;
        exp_t       e;
        v = vecs[idx];
        @(negedge Clk);
        Rst   = v[6];
        x     = v[5];
        y     = v[4];
        e.idx = idx;
        e.qA  = v[3];
        e.qB  = v[2];
        e.det = v[1:0];
        sbQ.push_back(e);
    endtask

    // Monitor: after every edge the DUTs present a fresh q, compared against the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                checkOutput("qA", e.idx, {7'd0, qA}, {7'd0, e.qA});
                checkOutput("qB", e.idx, {7'd0, qB}, {7'd0, e.qB});
`ifdef PP_1_DET_COUNT_EN
                checkOutput("det_count", e.idx, {6'd0, detB}, {6'd0, e.det});
`endif
            end
        end
    end

    initial begin
        checkCount = 0;
        failCount  = 0;
        Rst        = 1'b1;
        x          = 1'b0;
        y          = 1'b0;
        for (int i = 0; i < 37; i++) begin
            applyStimulus(i);
        end
        for (int i = 0; i < 10 && sbQ.size() != 0; i++) begin
            @(posedge Clk);
        end
        #2;
        if (sbQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", sbQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
